// File: rtl/mic_align_pkg.sv
// Shared helpers for the microphone frame aligner: saturating increment and
// packed-lane indexing.
package mic_align_pkg;

  // Increments count unless it already holds the all-ones value of `width` bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - width);
    return (count >= max_v) ? count : count + 32'd1;
  endfunction

  function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mic_frame_aligner_slot.sv
// One channel of the aligner: holding register, have flag, same-cycle bypass
// and overrun detection.
module align_slot #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_vld,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_complete,
  input  logic                     i_timeout,
  output logic                     o_acc,
  output logic                     o_have,
  output logic signed [DATA_W-1:0] o_lane,
  output logic                     o_overrun
);

  logic                     r_have;
  logic signed [DATA_W-1:0] r_hold;
  logic                     w_acc;

  assign w_acc = i_vld & i_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_have <= 1'b0;
    end else if (!i_en || i_complete) begin
      r_have <= 1'b0;
    end else if (i_timeout) begin
      // A sample arriving on the timeout cycle seeds the next frame.
      r_have <= w_acc;
    end else if (w_acc) begin
      r_have <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_acc) begin
      r_hold <= i_data;
    end
  end

  assign o_acc     = w_acc;
  assign o_have    = r_have;
  assign o_lane    = w_acc ? i_data : r_hold;
  assign o_overrun = w_acc & r_have & ~i_complete;

endmodule

// File: rtl/mic_frame_aligner.sv
// Aligns per-channel microphone samples into frames; owns the skew timer,
// completion decision and saturating diagnostic counters.
module mic_frame_aligner
  import mic_align_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     frame_valid,
  output logic [N_CH*DATA_W-1:0]   frame_data,
  output logic [N_CH-1:0]          frame_mask,
  output logic                     collecting,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         overrun_count
);

  localparam int TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [N_CH-1:0]          w_acc;
  logic [N_CH-1:0]          w_have;
  logic [N_CH-1:0]          w_ovr;
  logic [N_CH-1:0]          w_present;
  logic signed [DATA_W-1:0] w_lane [N_CH];
  logic                     w_complete;
  logic                     w_timeout;

  logic [TMR_W-1:0]         r_timer;
  logic                     r_fv;
  logic [N_CH-1:0]          r_fmask;
  logic signed [DATA_W-1:0] r_fd [N_CH];
  logic [CNT_W-1:0]         r_drop;
  logic [CNT_W-1:0]         r_ovr;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_slot
      align_slot #(.DATA_W(DATA_W)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_en       (ch_enable[g]),
        .i_vld      (ch_valid[g]),
        .i_data     (ch_data[lane_lo(g, DATA_W) +: DATA_W]),
        .i_complete (w_complete),
        .i_timeout  (w_timeout),
        .o_acc      (w_acc[g]),
        .o_have     (w_have[g]),
        .o_lane     (w_lane[g]),
        .o_overrun  (w_ovr[g])
      );

      // Disabled channels keep their last output sample.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_fd[g] <= '0;
        end else if (w_complete && ch_enable[g]) begin
          r_fd[g] <= w_lane[g];
        end
      end

      assign frame_data[lane_lo(g, DATA_W) +: DATA_W] = r_fd[g];
    end
  endgenerate

  assign w_present  = w_have | w_acc | ~ch_enable;
  assign w_complete = (&w_present) && (|ch_enable);
  assign w_timeout  = (TIMEOUT != 0) && (r_timer == TMR_W'(TIMEOUT)) && !w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (TIMEOUT == 0 || w_complete) begin
      r_timer <= '0;
    end else if (w_timeout || w_have == '0) begin
      r_timer <= (w_acc != '0) ? TMR_W'(1) : '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fv    <= 1'b0;
      r_fmask <= '0;
      r_drop  <= '0;
      r_ovr   <= '0;
    end else begin
      r_fv <= w_complete;
      if (w_complete) begin
        r_fmask <= ch_enable;
      end
      if (w_timeout) begin
        r_drop <= CNT_W'(sat_inc(32'(r_drop), CNT_W));
      end
      if (|w_ovr) begin
        r_ovr <= CNT_W'(sat_inc(32'(r_ovr), CNT_W));
      end
    end
  end

  assign frame_valid   = r_fv;
  assign frame_mask    = r_fmask;
  assign collecting    = |w_have;
  assign drop_count    = r_drop;
  assign overrun_count = r_ovr;

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Scoreboard bench for mic_frame_aligner with a cycle-level reference model.
module tb_mic_frame_aligner;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int TO = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_enable;
  logic [N-1:0]    ch_valid;
  logic [N*DW-1:0] ch_data;
  logic            frame_valid;
  logic [N*DW-1:0] frame_data;
  logic [N-1:0]    frame_mask;
  logic            collecting;
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   overrun_count;

  mic_frame_aligner #(.N_CH(N), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_enable     (ch_enable),
    .ch_valid      (ch_valid),
    .ch_data       (ch_data),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_mask    (frame_mask),
    .collecting    (collecting),
    .drop_count    (drop_count),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [50:0] sbq[$];

  logic [2:0]  m_have;
  logic [15:0] m_hold [3];
  logic [15:0] m_fd   [3];
  logic [2:0]  m_fmask;
  logic        m_fv;
  int          m_timer;
  int          m_drop;
  int          m_ovr;
  int          ovr_snap;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] en, input logic [2:0] vld,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [15:0] d [3];
    logic [2:0]  acc;
    logic        cmp, tmo, ovr;
    d[0] = a; d[1] = b; d[2] = c;
    if (r) begin
      m_have = '0; m_fmask = '0; m_fv = 1'b0; m_timer = 0; m_drop = 0; m_ovr = 0;
      for (int i = 0; i < 3; i++) begin m_hold[i] = '0; m_fd[i] = '0; end
    end else begin
      acc = vld & en;
      cmp = ((m_have | acc | ~en) == 3'b111) && (en != 3'b000);
      tmo = (m_timer == TO) && !cmp;
      ovr = ((acc & m_have) != 3'b000) && !cmp;
      m_fv = cmp;
      if (cmp) begin
        for (int i = 0; i < 3; i++)
          if (en[i]) m_fd[i] = acc[i] ? d[i] : m_hold[i];
        m_fmask = en;
        sbq.push_back({en, m_fd[2], m_fd[1], m_fd[0]});
      end
      if (cmp) m_timer = 0;
      else if (tmo || m_have == 3'b000) m_timer = (acc != 0) ? 1 : 0;
      else m_timer = m_timer + 1;
      for (int i = 0; i < 3; i++) begin
        if (!en[i] || cmp) m_have[i] = 1'b0;
        else if (tmo) m_have[i] = acc[i];
        else if (acc[i]) m_have[i] = 1'b1;
        if (acc[i]) m_hold[i] = d[i];
      end
      if (tmo && m_drop < 255) m_drop++;
      if (ovr && m_ovr < 255) m_ovr++;
    end
  endtask

  task automatic tick(input logic r, input logic [2:0] en, input logic [2:0] vld,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [50:0] e;
    rst = r; ch_enable = en; ch_valid = vld; ch_data = {c, b, a};
    model_step(r, en, vld, a, b, c);
    @(posedge clk);
    @(negedge clk);
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    if (frame_valid) begin
      chk("sb_depth", 64'(sbq.size() > 0), 64'(1));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_data", 64'(frame_data), 64'(e[47:0]));
        chk("sb_mask", 64'(frame_mask), 64'(e[50:48]));
      end
    end
    chk("frame_data", 64'(frame_data), 64'({m_fd[2], m_fd[1], m_fd[0]}));
    chk("frame_mask", 64'(frame_mask), 64'(m_fmask));
    chk("collecting", 64'(collecting), 64'(m_have != 3'b000));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overrun_count", 64'(overrun_count), 64'(m_ovr));
  endtask

  task automatic idle(input int n, input logic [2:0] en);
    for (int k = 0; k < n; k++) tick(1'b0, en, 3'b000, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    tick(1'b1, 3'b111, 3'b000, 16'h0, 16'h0, 16'h0);
    tick(1'b1, 3'b111, 3'b111, 16'h1, 16'h2, 16'h3);
    chk("rst_fv", 64'(frame_valid), 64'(0));
    chk("rst_data", 64'(frame_data), 64'(0));

    // Basic ordering: A, then C three cycles later, then B.
    tick(1'b0, 3'b111, 3'b001, 16'h1234, 16'h0, 16'h0);
    idle(2, 3'b111);
    tick(1'b0, 3'b111, 3'b100, 16'h0, 16'h0, 16'h0F00);
    idle(1, 3'b111);
    chk("t1_early", 64'(frame_valid), 64'(0));
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'hFFFE, 16'h0);
    chk("t1_fv", 64'(frame_valid), 64'(1));
    chk("t1_data", 64'(frame_data), 64'(48'h0F00_FFFE_1234));
    chk("t1_mask", 64'(frame_mask), 64'(3'b111));

    // Simultaneous arrivals, repeated every cycle.
    for (int k = 0; k < 6; k++)
      tick(1'b0, 3'b111, 3'b111, 16'(16'h100 + k), 16'(16'h200 + k), 16'(16'h8300 + k));
    chk("t2_fv", 64'(frame_valid), 64'(1));
    chk("t2_data", 64'(frame_data), 64'(48'h8305_0205_0105));
    chk("t2_ovr", 64'(overrun_count), 64'(0));
    idle(1, 3'b111);

    // Pure timeout: A and B arrive, C never does.
    tick(1'b0, 3'b111, 3'b001, 16'h0AAA, 16'h0, 16'h0);
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'h0BBB, 16'h0);
    idle(6, 3'b111);
    chk("t3_pre_drop", 64'(drop_count), 64'(0));
    idle(1, 3'b111);
    chk("t3_drop", 64'(drop_count), 64'(1));
    chk("t3_coll", 64'(collecting), 64'(0));

    // Timeout with an A sample on the timeout cycle seeding the next frame.
    tick(1'b0, 3'b111, 3'b001, 16'h0AAA, 16'h0, 16'h0);
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'h0BBB, 16'h0);
    idle(6, 3'b111);
    tick(1'b0, 3'b111, 3'b001, 16'h0A55, 16'h0, 16'h0);
    chk("t3b_drop", 64'(drop_count), 64'(2));
    chk("t3b_coll", 64'(collecting), 64'(1));
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'h0B55, 16'h0);
    tick(1'b0, 3'b111, 3'b100, 16'h0, 16'h0, 16'h0C55);
    chk("t3b_data", 64'(frame_data), 64'(48'h0C55_0B55_0A55));

    // Overrun on channel A.
    ovr_snap = m_ovr;
    tick(1'b0, 3'b111, 3'b001, 16'h0001, 16'h0, 16'h0);
    tick(1'b0, 3'b111, 3'b001, 16'h0002, 16'h0, 16'h0);
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'h00B0, 16'h0);
    tick(1'b0, 3'b111, 3'b100, 16'h0, 16'h0, 16'h00C0);
    chk("t4_data", 64'(frame_data), 64'(48'h00C0_00B0_0002));
    chk("t4_ovr", 64'(overrun_count), 64'(ovr_snap + 1));

    // Channel mask 101: B is ignored and its slot is left untouched.
    tick(1'b0, 3'b101, 3'b010, 16'h0, 16'hBEEF, 16'h0);
    tick(1'b0, 3'b101, 3'b111, 16'h5A5A, 16'hBEEF, 16'hC5C5);
    chk("t5_fv", 64'(frame_valid), 64'(1));
    chk("t5_data", 64'(frame_data), 64'(48'hC5C5_00B0_5A5A));
    chk("t5_mask", 64'(frame_mask), 64'(3'b101));
    tick(1'b0, 3'b101, 3'b001, 16'h1111, 16'h2222, 16'h0);
    tick(1'b0, 3'b101, 3'b110, 16'h0, 16'h3333, 16'h4444);
    chk("t5b_data", 64'(frame_data), 64'(48'h4444_00B0_1111));
    for (int k = 0; k < 3; k++) tick(1'b0, 3'b000, 3'b111, 16'h7, 16'h8, 16'h9);
    chk("t5_none_fv", 64'(frame_valid), 64'(0));
    chk("t5_none_coll", 64'(collecting), 64'(0));

    // Reset mid-collection.
    tick(1'b0, 3'b111, 3'b001, 16'h0AB1, 16'h0, 16'h0);
    tick(1'b1, 3'b111, 3'b000, 16'h0, 16'h0, 16'h0);
    chk("t6_rst_data", 64'(frame_data), 64'(0));
    chk("t6_rst_ovr", 64'(overrun_count), 64'(0));
    chk("t6_rst_drop", 64'(drop_count), 64'(0));
    tick(1'b0, 3'b111, 3'b010, 16'h0, 16'h0B66, 16'h0);
    tick(1'b0, 3'b111, 3'b100, 16'h0, 16'h0, 16'h0C66);
    chk("t6_nofv", 64'(frame_valid), 64'(0));
    tick(1'b0, 3'b111, 3'b001, 16'h0A66, 16'h0, 16'h0);
    chk("t6_data", 64'(frame_data), 64'(48'h0C66_0B66_0A66));
    idle(1, 3'b111);

    // Drop counter saturation.
    for (int k = 0; k < 300; k++) begin
      tick(1'b0, 3'b111, 3'b001, 16'(k), 16'h0, 16'h0);
      idle(8, 3'b111);
    end
    chk("sat_drop", 64'(drop_count), 64'(255));

    chk("sb_left", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mic_frame_aligner.md
Name: mic_frame_aligner

Overview:
Parametrised N-channel sample aligner between the I2S receivers and the TDOA stream units. Latches each channel's sample when its valid arrives, then emits one aligned frame when every enabled channel is present. Replaces ad-hoc all-flags-set sync logic and adds:
- channel enable mask
- skew timeout with frame drop
- overrun detection
- saturating diagnostics counters

Parameters:
N_CH, 3, number of microphone channels (2..8)
DATA_W, 16, signed sample width per channel
TIMEOUT, 64, max cycles from first arrival to completion; 0 disables timeout
CNT_W, 8, width of the saturating diagnostic counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_enable  in  N_CH  per-channel participation mask
ch_valid  in  N_CH  per-channel one-cycle sample strobe
ch_data  in  N_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W]
frame_valid  out  1  one-cycle pulse: aligned frame available
frame_data  out  N_CH*DATA_W  aligned samples; held stable until the next frame_valid
frame_mask  out  N_CH  ch_enable value captured at frame completion
collecting  out  1  high while at least one enabled channel is latched
drop_count  out  CNT_W  frames dropped by timeout; saturates at all-ones
overrun_count  out  CNT_W  repeat arrivals before completion; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge): all outputs are 0; internal state is cleared (have flags, timer, holding registers). Reset takes priority over every other event.
- Definitions:
  - acc = ch_valid & ch_enable (accepted arrivals this cycle)
  - present = have | acc | ~ch_enable
- Capture: for each channel with acc[i], the holding register is loaded with ch_data[i] and have[i] is set.
- Disabled channels: ch_valid is ignored. Clearing ch_enable[i] while have[i]=1 clears have[i] on the next edge. Its frame_data slot keeps its last value.
- Completion: when present is all ones and ch_enable != 0, on the next edge:
  - frame_valid=1
  - frame_data = holding registers, with same-cycle arrivals bypassed in
  - frame_mask = ch_enable
  - have cleared and timer cleared
- Latency: exactly 1 cycle from the last required arrival to frame_valid.
- ch_enable == 0: no frames; have stays 0.
- Overrun: acc[i] while have[i]=1 and the frame is not completing this cycle:
  - the newer data overwrites the holding register
  - overrun_count increments by 1 (once per cycle, regardless of how many channels overrun)
  - the timer is not restarted
- States:
  - IDLE: have==0.
  - IDLE -> COLLECT on any acc without completion; the timer loads 1.
  - COLLECT: the timer increments each cycle.
  - COLLECT -> IDLE on completion.
  - COLLECT -> IDLE on timeout.
  - Single-channel enable completes directly from IDLE (IDLE -> IDLE with frame_valid).
- Timeout: when TIMEOUT != 0 and the timer == TIMEOUT with no completion this cycle:
  - have is replaced by acc (same-cycle arrivals seed the next frame)
  - drop_count increments
  - the timer becomes 1 if acc != 0, otherwise 0
  - no frame_valid.
- Completion beats timeout when both occur in the same cycle.
- collecting equals (have != 0), registered.
- Counters: saturate, never wrap; cleared only by rst.
- Timer width: $clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Package mic_align_pkg: function sat_inc(count, width) and the lane-slice helper for packed channel data.
- One sub-module, align_slot (instantiated N_CH times): holding register, have flag, bypass mux, overrun detect. The timer, completion and counter logic stay in mic_frame_aligner.

Test Plan:
1. Basic ordering: N_CH=3, all enabled. valid A=0x1234 @t, C=0x0F00 @t+3, B=0xFFFE @t+5 -> frame_valid only @t+6 with frame_data {0x0F00,0xFFFE,0x1234}; frame_mask=3'b111.
2. Simultaneous: all three valid in one cycle -> frame_valid next cycle. Back-to-back repeat of this every cycle -> a frame every cycle, overrun_count stays 0.
3. Timeout: TIMEOUT=8; A and B arrive, C silent -> no frame; drop_count=1 exactly 8 cycles after A; collecting falls. A valid on the timeout cycle -> collecting stays 1 and that A sample appears in the next frame.
4. Overrun: A=0x0001, then A=0x0002, then B and C -> a single frame with A=0x0002; overrun_count=1.
5. Mask: ch_enable=3'b101, B toggling -> frames formed from A and C only; frame_mask=3'b101; the B slot is unchanged. ch_enable=0 -> no frames.
6. Reset mid-collection: A latched, rst for one cycle, then B and C arrive -> no frame until a new A arrives; all outputs and counters read 0 after rst. Saturation check: drive 300 timeouts with CNT_W=8 -> drop_count=255.
